// File: rtl/uart_tx_fifo_if.sv
// CPU-facing signal bundle of the UART transmit channel.
// The master drives the write and register strobes; the slave returns line and status.
interface uart_tx_fifo_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] access_addr;
    logic       reg_w_en;
    logic       tx;
    logic       busy_flag;
    logic       full_flag;
    logic       int_req;

    modport master (
        output wr_en,
        output wr_data,
        output access_addr,
        output reg_w_en,
        input  tx,
        input  busy_flag,
        input  full_flag,
        input  int_req
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  access_addr,
        input  reg_w_en,
        output tx,
        output busy_flag,
        output full_flag,
        output int_req
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmit channel: byte FIFO feeding an 8N1 LSB-first serialiser,
// with a sticky transmit-complete interrupt cleared by a register write.
module uart_tx_fifo #(
    parameter int unsigned BAUD_DIV     = 434,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [7:0]  INT_CLR_ADDR = 8'd253
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_idx_nxt;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [BAUD_W-1:0] w_baud_cnt_nxt;
    logic              r_tx;
    logic              w_tx_nxt;
    logic              r_busy;
    logic              r_full;
    logic              r_int_req;
    logic              r_done;
    logic              w_done;
    logic              w_push;
    logic              w_pop;
    logic              w_not_empty;
    logic              w_full_pre;
    logic              w_baud_end;
    logic              w_int_clr;

    // Full is judged on the pre-edge count, so a push while full is lost even if a pop coincides.
    assign w_full_pre  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_not_empty = (r_count != '0);
    assign w_push      = bus.wr_en && !w_full_pre;
    assign w_baud_end  = (r_baud_cnt == BAUD_W'(BAUD_DIV - 1));
    assign w_int_clr   = bus.reg_w_en && (bus.access_addr == INT_CLR_ADDR);
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
        end
    end

    // Serialiser next-state; tx is computed from the current state so the line lags the FSM by one cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_baud_cnt_nxt = r_baud_cnt + BAUD_W'(1);
        w_done         = 1'b0;
        w_tx_nxt       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_baud_cnt_nxt = '0;
                w_bit_idx_nxt  = '0;
                if (w_not_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx_nxt = 1'b0;
                if (w_baud_end) begin
                    w_baud_cnt_nxt = '0;
                    w_bit_idx_nxt  = '0;
                    w_state_nxt    = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_baud_end) begin
                    w_baud_cnt_nxt = '0;
                    w_shift_nxt    = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_cnt_nxt = '0;
                    if (w_not_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rd_ptr];
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus registered line/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_int_req  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (w_state_nxt != S_IDLE) || w_not_empty;
            r_done     <= w_done;
            // Interrupt follows the end of the stop bit on the line; set beats a coincident clear.
            if (r_done) begin
                r_int_req <= 1'b1;
            end else if (w_int_clr) begin
                r_int_req <= 1'b0;
            end
        end
    end

    assign bus.tx        = r_tx;
    assign bus.busy_flag = r_busy;
    assign bus.full_flag = r_full;
    assign bus.int_req   = r_int_req;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue/timeline reference model checked every cycle, vector table,
// directed corner sequences, a line decoder for byte order, and randomized traffic.
module tb_uart_tx_fifo;
    localparam int unsigned BD       = 16;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned FRAME    = 10 * BD;
    localparam int unsigned DEF_BD   = 434;
    localparam logic [7:0]  CLR_ADDR = 8'd253;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr    = 1'b0;
    logic       rw    = 1'b0;
    logic [7:0] wd    = 8'h00;
    logic [7:0] addr  = 8'h00;
    logic       dwr   = 1'b0;
    logic       drw   = 1'b0;
    logic [7:0] dwd   = 8'h00;
    logic [7:0] daddr = 8'h00;
    int         total = 0;
    int         bad   = 0;

    uart_tx_fifo_if bus ();
    uart_tx_fifo_if bus_d ();

    assign bus.wr_en         = wr;
    assign bus.wr_data       = wd;
    assign bus.reg_w_en      = rw;
    assign bus.access_addr   = addr;
    assign bus_d.wr_en       = dwr;
    assign bus_d.wr_data     = dwd;
    assign bus_d.reg_w_en    = drw;
    assign bus_d.access_addr = daddr;

    uart_tx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH), .INT_CLR_ADDR(CLR_ADDR)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    uart_tx_fifo u_def (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_d)
    );

    always #10 clk = ~clk;

    // Reference model: accepted bytes queue, time the serialiser frees up, last frame start.
    logic [7:0] q[$];
    logic [7:0] acc_q[$];
    logic [7:0] rx_q[$];
    longint     cyc;
    longint     free_at;
    longint     last_pop;
    logic [7:0] cur;
    bit         have;
    bit         m_int;
    bit         m_done_pend;
    bit         m_busy;
    bit         m_full;
    bit         m_tx;
    logic       prev_tx;
    bit         rx_act;
    int         rx_t;
    logic [7:0] rx_sh;

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rw;
        logic [7:0] addr;
        logic       tx;
        logic       busy;
        logic       full;
        logic       irq;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cyc         = 0;
        free_at     = 0;
        last_pop    = 0;
        cur         = 8'h00;
        have        = 1'b0;
        m_int       = 1'b0;
        m_done_pend = 1'b0;
        prev_tx     = 1'b1;
        rx_act      = 1'b0;
        rx_t        = 0;
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        bit     pre_ne;
        bit     pre_full;
        bit     push;
        bit     clr;
        longint k;
        int     kk;
        @(posedge clk);
        pre_ne   = (q.size() != 0);
        pre_full = (q.size() == DEPTH);
        push     = wr && !pre_full;
        clr      = rw && (addr == CLR_ADDR);
        if (m_done_pend) m_int = 1'b1;
        else if (clr)    m_int = 1'b0;
        m_done_pend = 1'b0;
        if (cyc >= free_at) begin
            if (pre_ne) begin
                cur      = q.pop_front();
                last_pop = cyc;
                have     = 1'b1;
                free_at  = cyc + FRAME;
            end else if (have && cyc == free_at) begin
                m_done_pend = 1'b1;
            end
        end
        if (push) begin
            q.push_back(wd);
            acc_q.push_back(wd);
        end
        m_busy = (cyc < free_at) || pre_ne;
        m_full = (q.size() == DEPTH);
        m_tx   = 1'b1;
        if (have && cyc > last_pop && cyc <= last_pop + FRAME) begin
            k = (cyc - last_pop - 1) / BD;
            if (k == 0)      m_tx = 1'b0;
            else if (k <= 8) m_tx = cur[k-1];
        end
        #1;
        chk($sformatf("tx@%0d", cyc), bus.tx, m_tx);
        chk($sformatf("busy@%0d", cyc), bus.busy_flag, m_busy);
        chk($sformatf("full@%0d", cyc), bus.full_flag, m_full);
        chk($sformatf("int@%0d", cyc), bus.int_req, m_int);
        // Line decoder sampling mid-bit.
        if (!rx_act) begin
            if (prev_tx && !bus.tx) begin
                rx_act = 1'b1;
                rx_t   = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % BD == BD / 2) begin
                kk = rx_t / BD;
                if (kk >= 1 && kk <= 8) begin
                    rx_sh[kk-1] = bus.tx;
                end else if (kk == 9) begin
                    rx_q.push_back(rx_sh);
                    rx_act = 1'b0;
                end
            end
        end
        prev_tx = bus.tx;
        cyc++;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 12 * FRAME; t++) begin
            if (q.size() == 0 && cyc > free_at + 2) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) chk(name, 0, 1);
    endtask

    task automatic cmp_rx(input string name);
        chk({name, "_count"}, rx_q.size(), acc_q.size());
        for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", name, i), rx_q[i], acc_q[i]);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] exp_bits;
        logic [7:0] burst_exp[10];
        bit         found;

        vt[0] = '{1'b0, 8'h00, 1'b1, 8'd252, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[1] = '{1'b0, 8'h00, 1'b1, 8'd0,   1'b1, 1'b0, 1'b0, 1'b1};
        vt[2] = '{1'b0, 8'h00, 1'b0, 8'd253, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[3] = '{1'b1, 8'h3C, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b1};
        vt[4] = '{1'b0, 8'h00, 1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 1'b1};
        vt[5] = '{1'b0, 8'h00, 1'b1, 8'd253, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[6] = '{1'b0, 8'h00, 1'b1, 8'd253, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[7] = '{1'b1, 8'h11, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0};
        vt[8] = '{1'b1, 8'h22, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0};
        exp_bits = {1'b1, 8'h55, 1'b0};
        model_reset();

        // Reset values on both instances.
        #2 rst_n = 1'b0;
        #3;
        chk("rst_tx", bus.tx, 1);
        chk("rst_busy", bus.busy_flag, 0);
        chk("rst_full", bus.full_flag, 0);
        chk("rst_int", bus.int_req, 0);
        chk("rst_def_tx", bus_d.tx, 1);
        chk("rst_def_busy", bus_d.busy_flag, 0);
        chk("rst_def_full", bus_d.full_flag, 0);
        chk("rst_def_int", bus_d.int_req, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Single byte 0x55 at the default 434-cycle bit time; this edge is E.
        dwd = 8'h55;
        dwr = 1'b1;
        step();
        dwr = 1'b0;
        chk("def_busy_e0", bus_d.busy_flag, 0);
        for (int n = 1; n <= 4342; n++) begin
            step();
            if (n == 1) begin
                chk("def_tx_e1", bus_d.tx, 1);
                chk("def_busy_e1", bus_d.busy_flag, 1);
            end
            if (n == 2) chk("def_tx_fall", bus_d.tx, 0);
            if (n >= 2 && (n - 2) % DEF_BD == DEF_BD / 2)
                chk($sformatf("def_bit%0d", (n - 2) / DEF_BD), bus_d.tx, exp_bits[(n - 2) / DEF_BD]);
            if (n == 4340) chk("def_busy_stop", bus_d.busy_flag, 1);
            if (n == 4341) begin
                chk("def_int_early", bus_d.int_req, 0);
                chk("def_busy_fall", bus_d.busy_flag, 0);
                chk("def_tx_stop_end", bus_d.tx, 1);
            end
            if (n == 4342) chk("def_int_rise", bus_d.int_req, 1);
        end
        drw   = 1'b1;
        daddr = CLR_ADDR;
        step();
        drw = 1'b0;
        chk("def_int_clr", bus_d.int_req, 0);

        // Get int_req set on the main instance, then apply the vector table.
        wr = 1'b1;
        wd = 8'hA5;
        step();
        wr = 1'b0;
        repeat (FRAME + 40) step();
        for (int i = 0; i < 9; i++) begin
            wr   = vt[i].wr;
            wd   = vt[i].wd;
            rw   = vt[i].rw;
            addr = vt[i].addr;
            step();
            chk($sformatf("vec%0d_tx", i), bus.tx, vt[i].tx);
            chk($sformatf("vec%0d_busy", i), bus.busy_flag, vt[i].busy);
            chk($sformatf("vec%0d_full", i), bus.full_flag, vt[i].full);
            chk($sformatf("vec%0d_int", i), bus.int_req, vt[i].irq);
        end
        wr = 1'b0;
        rw = 1'b0;

        // Clear held across the STOP->IDLE edge and the following one: set must win.
        found = 1'b0;
        for (int t = 0; t < 4 * FRAME && !found; t++) begin
            if (have && q.size() == 0 && cyc == free_at) found = 1'b1;
            else step();
        end
        if (!found) chk("timeout_same_edge", 0, 1);
        else begin
            rw   = 1'b1;
            addr = CLR_ADDR;
            step();
            step();
            rw = 1'b0;
            chk("clr_same_edge", bus.int_req, 1);
            rw = 1'b1;
            step();
            rw = 1'b0;
            chk("clr_after", bus.int_req, 0);
        end
        repeat (4) step();

        // Burst of 9 while a lead frame is in flight: FIFO fills on the 8th, 0x08 is dropped.
        rx_q.delete();
        acc_q.delete();
        wr = 1'b1;
        wd = 8'hEE;
        step();
        wr = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 9; i++) begin
            wr = 1'b1;
            wd = 8'(i);
            step();
            if (i == 6) chk("burst_not_full7", bus.full_flag, 0);
            if (i >= 7) chk($sformatf("burst_full%0d", i), bus.full_flag, 1);
        end
        wr = 1'b0;
        // Push while full on the pop edge: dropped, count falls to 7, one more push refills.
        found = 1'b0;
        for (int t = 0; t < 2 * FRAME && !found; t++) begin
            if (cyc == free_at) found = 1'b1;
            else step();
        end
        if (!found) chk("timeout_full_pop", 0, 1);
        wr = 1'b1;
        wd = 8'h99;
        step();
        chk("pop_drop_full", bus.full_flag, 0);
        wd = 8'h5A;
        step();
        wr = 1'b0;
        chk("refill_full", bus.full_flag, 1);
        drain("drain_burst");
        burst_exp[0] = 8'hEE;
        for (int i = 1; i < 9; i++) burst_exp[i] = 8'(i - 1);
        burst_exp[9] = 8'h5A;
        chk("burst_rx_count", rx_q.size(), 10);
        for (int i = 0; i < 10 && i < rx_q.size(); i++)
            chk($sformatf("burst_rx%0d", i), rx_q[i], burst_exp[i]);

        // Reset during data bit 3 of 0xF0 with three bytes queued and int_req set.
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1;
            wd = (i == 0) ? 8'hF0 : 8'(i);
            step();
        end
        wr = 1'b0;
        found = 1'b0;
        for (int t = 0; t < FRAME && !found; t++) begin
            if (cyc - last_pop == 4 * BD + BD / 2 + 2) found = 1'b1;
            else step();
        end
        if (!found) chk("timeout_mid_frame", 0, 1);
        chk("pre_rst_tx", bus.tx, 0);
        chk("pre_rst_busy", bus.busy_flag, 1);
        chk("pre_rst_int", bus.int_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", bus.tx, 1);
        chk("mid_rst_busy", bus.busy_flag, 0);
        chk("mid_rst_full", bus.full_flag, 0);
        chk("mid_rst_int", bus.int_req, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        rx_q.delete();
        acc_q.delete();
        repeat (2 * FRAME) step();
        chk("post_rst_rx", rx_q.size(), 0);

        // Wrap-around: 20 bytes through an 8-entry FIFO, order checked against constants.
        for (int i = 0; i < 20; i++) begin
            for (int t = 0; t < 2 * FRAME && q.size() == DEPTH; t++) step();
            wr = 1'b1;
            wd = 8'hA0 + 8'(i);
            step();
            wr = 1'b0;
        end
        drain("drain_wrap");
        chk("wrap_rx_count", rx_q.size(), 20);
        for (int i = 0; i < 20 && i < rx_q.size(); i++)
            chk($sformatf("wrap_rx%0d", i), rx_q[i], 8'hA0 + 8'(i));

        // Randomized traffic with register writes mixed in.
        rx_q.delete();
        acc_q.delete();
        for (int i = 0; i < 3000; i++) begin
            wr   = ($urandom_range(0, 2) == 0);
            wd   = 8'($urandom);
            rw   = ($urandom_range(0, 9) == 0);
            addr = ($urandom_range(0, 1) == 1) ? CLR_ADDR : 8'($urandom);
            step();
        end
        wr = 1'b0;
        rw = 1'b0;
        drain("drain_rand");
        cmp_rx("rand_rx");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
